ysyx_22041412_muldiv_iter: RTL and testbench

- Parametrised, multi-cycle RV64M multiply/divide unit.
- Covers all eight M-extension func3 operations plus the 32-bit W variants.
- Uses a valid/ready handshake on both input and output, so the EXU can stall cleanly on a long-latency op.
- Uses radix-2 shift-add multiply and restoring divide, one bit per cycle, with an explicit sign-fix stage.

---
 rtl/ysyx_22041412_muldiv_iter.sv | 227 ++++++++++++++++++++++
 tb/tb_ysyx_22041412_muldiv_iter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_muldiv_iter.sv
// ysyx_22041412_muldiv_iter: iterative RV64M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle, followed by a single sign-fix cycle. Valid/ready
// handshakes on both the request and the result side.
// Optional macro YSYX_22041412_MULDIV_EARLY_OUT_EN: divide by zero, signed
// overflow and multiplies with a zero operand skip the iteration phase.
module ysyx_22041412_muldiv_iter #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      func3,
   input  logic            word,
   input  logic [XLEN-1:0] rsA,
   input  logic [XLEN-1:0] rsB,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] data
);

   localparam int HALF = XLEN / 2;
   localparam int CW   = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_e;

   state_e              state_q,  state_d;
   logic [2:0]          func3_q,  func3_d;
   logic                word_q,   word_d;
   logic                neg_a_q,  neg_a_d;
   logic                neg_b_q,  neg_b_d;
   logic                div0_q,   div0_d;
   logic [CW-1:0]       count_q,  count_d;
   // Multiply: running product. Divide: {remainder, dividend/quotient}.
   logic [2*XLEN-1:0]   acc_q,    acc_d;
   // Multiply: left-shifting multiplicand. Divide: divisor in the low half.
   logic [2*XLEN-1:0]   mcand_q,  mcand_d;
   // Multiply: right-shifting multiplier. Unused for divide.
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [XLEN-1:0]     data_q,   data_d;

   // Operand preparation: W mode narrows to the low half, then sign- or
   // zero-extends so the rest of the datapath only sees XLEN-wide values.
   function automatic logic [XLEN-1:0] extend_op(input logic [XLEN-1:0] v,
                                                 input logic            w,
                                                 input logic            s);
      if (!w) return v;
      return s ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : {{HALF{1'b0}}, v[HALF-1:0]};
   endfunction

   logic            sgn_a_in, sgn_b_in;
   logic            neg_a_in, neg_b_in;
   logic            div0_in;
   logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b;

   assign sgn_a_in = (func3 != 3'b011) && (func3 != 3'b101) && (func3 != 3'b111);
   assign sgn_b_in = sgn_a_in && (func3 != 3'b010);
   assign ext_a    = extend_op(rsA, word, sgn_a_in);
   assign ext_b    = extend_op(rsB, word, sgn_b_in);
   assign neg_a_in = sgn_a_in & ext_a[XLEN-1];
   assign neg_b_in = sgn_b_in & ext_b[XLEN-1];
   assign mag_a    = neg_a_in ? -ext_a : ext_a;
   assign mag_b    = neg_b_in ? -ext_b : ext_b;
   assign div0_in  = func3[2] && (ext_b == '0);

`ifdef YSYX_22041412_MULDIV_EARLY_OUT_EN
   localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

   logic ovf_in, mzero_in;

   assign ovf_in   = func3[2] && sgn_a_in && (ext_a == (word ? MIN_W : MIN_D)) &&
                     (ext_b == '1);
   assign mzero_in = !func3[2] && ((ext_a == '0) || (ext_b == '0));
`endif

   // One iteration step. Restoring divide: the partial remainder never
   // exceeds 2*divisor-1, so XLEN+1 bits are enough to see the borrow.
   logic [2*XLEN-1:0] mul_acc;
   logic [XLEN:0]     rem_shift, rem_diff;
   logic              rem_ge;

   assign mul_acc   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign rem_diff  = rem_shift - {1'b0, mcand_q[XLEN-1:0]};
   assign rem_ge    = ~rem_diff[XLEN];

   // Sign fix and result selection, consumed in the FIX state.
   logic              res_neg, w_illegal;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot, rem, res_full;

   assign res_neg   = neg_a_q ^ neg_b_q;
   assign prod      = res_neg ? -acc_q : acc_q;
   assign quot      = div0_q ? '1 : (res_neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
   assign rem       = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
   assign w_illegal = word_q && !func3_q[2] && (func3_q[1:0] != 2'b00);

   // Select the architectural result for the latched func3.
   always_comb begin
      res_full = prod[XLEN-1:0];
      case (func3_q)
         3'b001, 3'b010, 3'b011: res_full = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         res_full = quot;
         3'b110, 3'b111:         res_full = rem;
         default:                res_full = prod[XLEN-1:0];
      endcase
   end

   // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // case statement can leave one unassigned and infer a latch.
      state_d  = state_q;
      func3_d  = func3_q;
      word_d   = word_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      div0_d   = div0_q;
      count_d  = count_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      data_d   = data_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               func3_d  = func3;
               word_d   = word;
               neg_a_d  = neg_a_in;
               neg_b_d  = neg_b_in;
               div0_d   = div0_in;
               count_d  = word ? CW'(HALF) : CW'(XLEN);
               acc_d    = '0;
               mcand_d  = {{XLEN{1'b0}}, mag_a};
               mplier_d = mag_b;
               if (func3[2]) begin
                  // W-mode dividend is pre-aligned to the top so the same
                  // MSB-first shift works for both widths.
                  mcand_d  = {{XLEN{1'b0}}, mag_b};
                  mplier_d = '0;
                  acc_d    = {{XLEN{1'b0}}, (word ? (mag_a << HALF) : mag_a)};
               end
               state_d = S_CALC;
`ifdef YSYX_22041412_MULDIV_EARLY_OUT_EN
               // Preload the accumulator with what the full iteration would
               // have produced, so FIX needs no special cases beyond div0.
               if (div0_in) begin
                  acc_d   = {mag_a, {XLEN{1'b0}}};
                  state_d = S_FIX;
               end else if (ovf_in) begin
                  acc_d   = {{XLEN{1'b0}}, mag_a};
                  state_d = S_FIX;
               end else if (mzero_in) begin
                  acc_d   = '0;
                  state_d = S_FIX;
               end
`endif
            end
         end
         S_CALC: begin
            if (func3_q[2]) begin
               acc_d = {(rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], rem_ge};
            end else begin
               acc_d    = mul_acc;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (w_illegal)   data_d = '0;
            else if (word_q) data_d = {{HALF{res_full[HALF-1]}}, res_full[HALF-1:0]};
            else             data_d = res_full;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; synchronous reset clears everything.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         state_q  <= S_IDLE;
         func3_q  <= '0;
         word_q   <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         div0_q   <= 1'b0;
         count_q  <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         func3_q  <= func3_d;
         word_q   <= word_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         div0_q   <= div0_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         data_q   <= data_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign data      = data_q;

endmodule

// File: tb/tb_ysyx_22041412_muldiv_iter.sv
// Self-checking bench for ysyx_22041412_muldiv_iter (XLEN=64): a vector table
// driven through a scoreboard queue, plus hand-written sequences for output
// back-pressure and reset during iteration.
module tb_ysyx_22041412_muldiv_iter;

   localparam int XLEN = 64;
`ifdef YSYX_22041412_MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      func3;
   logic            word;
   logic [XLEN-1:0] rsA;
   logic [XLEN-1:0] rsB;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] data;

   always #5 clk = ~clk;

   ysyx_22041412_muldiv_iter #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .func3     (func3),
      .word      (word),
      .rsA       (rsA),
      .rsB       (rsB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data      (data)
   );

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      bit          eo;   // eligible for the early-out path
   } vec_t;

   typedef struct {
      string       name;
      logic [63:0] data;
      int          lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input bit w, input bit eo);
      if (EARLY && eo) return 2;
      return w ? (XLEN / 2 + 2) : (XLEN + 2);
   endfunction

   // Present a request, wait (bounded) for acceptance, record the expectation.
   task automatic issue(input string name, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input bit eo);
      int guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      func3    = f3;
      word     = w;
      rsA      = a;
      rsB      = b;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check({name, "_in_ready"}, {63'b0, in_ready}, 64'd1);
      @(posedge clk);
      sb.push_back('{name, exp, exp_lat(w, eo)});
      #1 in_valid = 1'b0;
   endtask

   // Count edges from the accept edge (inclusive) until out_valid is seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (1) begin
         @(negedge clk);
         if (out_valid) break;
         lat++;
         if (lat > 200) break;
      end
   endtask

   // Pop the oldest expectation, compare, then complete the output handshake.
   task automatic collect();
      int   lat;
      exp_t e;
      wait_valid(lat);
      if (sb.size() == 0) begin
         check("scoreboard_empty", 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         check({e.name, "_data"}, data, e.data);
         check({e.name, "_lat"}, 64'(lat), 64'(e.lat));
         check({e.name, "_busy"}, {63'b0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      exp_t e;

      vecs.push_back('{"mul_m1x7",     3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0});
      vecs.push_back('{"mulhu_m1x7",   3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'h0000_0000_0000_0006, 1'b0});
      vecs.push_back('{"mulh_2p62x4",  3'b001, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'h0000_0000_0000_0001, 1'b0});
      vecs.push_back('{"mul_big",      3'b000, 1'b0, 64'h0000_0001_2345_6789, 64'h1000, 64'h0000_1234_5678_9000, 1'b0});
      vecs.push_back('{"mul_zero",     3'b000, 1'b0, 64'd0, 64'd123, 64'd0, 1'b1});
      vecs.push_back('{"div_m7_2",     3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
      vecs.push_back('{"rem_m7_2",     3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      vecs.push_back('{"remu_m7_2",    3'b111, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd1, 1'b0});
      vecs.push_back('{"divu_100_7",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0});
      vecs.push_back('{"divu_by0",     3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
      vecs.push_back('{"rem_by0",      3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1});
      vecs.push_back('{"div_ovf",      3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1});
      vecs.push_back('{"rem_ovf",      3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1});
      vecs.push_back('{"divuw_msb",    3'b101, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0});
      vecs.push_back('{"mulw_wrap",    3'b000, 1'b1, 64'h0000_0000_0001_0000, 64'h0001_0000, 64'd0, 1'b0});
      vecs.push_back('{"divw_m7_2",    3'b100, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
      vecs.push_back('{"remw_by0",     3'b110, 1'b1, 64'h0000_0001_8000_0005, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0005, 1'b1});
      vecs.push_back('{"divw_ovf",     3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1});
      vecs.push_back('{"remuw_15",     3'b111, 1'b1, 64'hABCD_0000_FFFF_FFFF, 64'h10, 64'd15, 1'b0});
      vecs.push_back('{"mulhw_illegal",3'b001, 1'b1, 64'd3, 64'd5, 64'd0, 1'b0});

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      func3     = 3'b000;
      word      = 1'b0;
      rsA       = '0;
      rsB       = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", {63'b0, in_ready}, 64'd1);
      check("reset_out_valid", {63'b0, out_valid}, 64'd0);
      check("reset_data", data, 64'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         issue(vecs[i].name, vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].eo);
         collect();
      end

      // Back-pressure: result held for 10 cycles, then handshake with a new
      // request pending in the same cycle.
      issue("hold_divu", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0);
      wait_valid(lat);
      e = sb.pop_front();
      check("hold_divu_data", data, e.data);
      check("hold_divu_lat", 64'(lat), 64'(e.lat));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_data", data, 64'd14);
         check("hold_in_ready", {63'b0, in_ready}, 64'd0);
         check("hold_out_valid", {63'b0, out_valid}, 64'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      func3     = 3'b000;
      word      = 1'b0;
      rsA       = 64'h0000_0001_2345_6789;
      rsB       = 64'h1000;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("handoff_out_valid", {63'b0, out_valid}, 64'd0);
      check("handoff_in_ready", {63'b0, in_ready}, 64'd1);
      @(posedge clk);
      sb.push_back('{"handoff_mul", 64'h0000_1234_5678_9000, exp_lat(1'b0, 1'b0)});
      #1 in_valid = 1'b0;
      collect();

      // Reset in the middle of CALC aborts the operation.
      issue("abort_mul", 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      e   = sb.pop_back();
      @(negedge clk);
      check("abort_in_ready", {63'b0, in_ready}, 64'd1);
      check("abort_out_valid", {63'b0, out_valid}, 64'd0);
      check("abort_data", data, 64'd0);
      rst = 1'b0;
      repeat (80) @(negedge clk);
      check("abort_no_result", {63'b0, out_valid}, 64'd0);
      check("abort_data_hold", data, 64'd0);

      issue("mulhsu_m1x2", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      collect();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
